// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared opcodes, instruction field positions and FSM encoding
// Purpose: single source of truth for the sequencer and its decoder.
// Ports: none (package).
package proc_pkg;

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_LOADI = 3'b001;
  localparam logic [2:0] OP_ADD   = 3'b010;
  localparam logic [2:0] OP_SUB   = 3'b011;
  localparam logic [2:0] OP_MOV   = 3'b100;
  localparam logic [2:0] OP_INC   = 3'b101;
  localparam logic [2:0] OP_JMPZ  = 3'b110;
  localparam logic [2:0] OP_HALT  = 3'b111;

  // JMPZ borrows the MOV ALU function so the ALU passes rd through for the zero test
  localparam logic [2:0] ALU_JMPZ_FUNC = 3'b100;

  localparam int IR_W    = 8;
  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int RD_BIT  = 4;
  localparam int IMM_MSB = 3;
  localparam int IMM_LSB = 0;
  localparam int RS_BIT  = 0;
  localparam int IMM_W   = IMM_MSB - IMM_LSB + 1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_DECODE    = 3'd2,
    ST_EXECUTE   = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_STEP_WAIT = 3'd5,
    ST_HALT      = 3'd6
  } state_t;

endpackage

// File: rtl/seq_decode.sv
// rtl/seq_decode.sv - combinational instruction decoder
// Purpose: splits the instruction register into fields and control flags.
// Ports: i_ir (instruction) -> o_rd, o_rb (read-B address, rd for JMPZ),
//        o_imm (imm field), o_wr_en, o_jmpz, o_halt, o_bsel, o_alu_func.
module seq_decode
  import proc_pkg::*;
(
  input  logic [IR_W-1:0]  i_ir,
  output logic             o_rd,
  output logic             o_rb,
  output logic [IMM_W-1:0] o_imm,
  output logic             o_wr_en,
  output logic             o_jmpz,
  output logic             o_halt,
  output logic             o_bsel,
  output logic [2:0]       o_alu_func
);

  logic [2:0] w_op;

  always_comb begin
    w_op       = i_ir[OP_MSB:OP_LSB];
    o_rd       = i_ir[RD_BIT];
    o_imm      = i_ir[IMM_MSB:IMM_LSB];
    o_jmpz     = (w_op == OP_JMPZ);
    o_halt     = (w_op == OP_HALT);
    o_wr_en    = (w_op == OP_LOADI) || (w_op == OP_ADD) || (w_op == OP_SUB) ||
                 (w_op == OP_MOV)   || (w_op == OP_INC);
    o_bsel     = (w_op == OP_LOADI) || (w_op == OP_INC);
    // JMPZ tests rd itself, so read port B also points at rd
    o_rb       = o_jmpz ? i_ir[RD_BIT] : i_ir[RS_BIT];
    o_alu_func = o_jmpz ? ALU_JMPZ_FUNC : w_op;
  end

endmodule

// File: rtl/proc_sequencer.sv
// rtl/proc_sequencer.sv - multi-cycle instruction sequencer with single-step
// Purpose: fetch/decode/execute/writeback control for a tiny 2-register core.
// Ports: clk, reset (async active-low), start, step_en, step;
//        imem_req/imem_addr/imem_ack/imem_data fetch handshake;
//        rf_ra/rf_rb/rf_wa/rf_we register-file control;
//        alu_func/alu_bsel/imm/alu_zero ALU control; busy/halted/pc status.
module proc_sequencer
  import proc_pkg::*;
#(
  parameter int PC_W   = 4,
  parameter int DATA_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              step_en,
  input  logic              step,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [IR_W-1:0]   imem_data,
  output logic              rf_ra,
  output logic              rf_rb,
  output logic              rf_wa,
  output logic              rf_we,
  output logic [2:0]        alu_func,
  output logic              alu_bsel,
  output logic [DATA_W-1:0] imm,
  input  logic              alu_zero,
  output logic              busy,
  output logic              halted,
  output logic [PC_W-1:0]   pc
);

  state_t           r_state;
  state_t           w_next_state;
  logic [PC_W-1:0]  r_pc;
  logic [IR_W-1:0]  r_ir;
  logic             r_zero;

  logic             w_rd;
  logic             w_rb;
  logic [IMM_W-1:0] w_imm;
  logic             w_wr_en;
  logic             w_jmpz;
  logic             w_halt;
  logic             w_bsel;
  logic [2:0]       w_alu_func;
  logic             w_start_ok;

  seq_decode u_decode (
    .i_ir       (r_ir),
    .o_rd       (w_rd),
    .o_rb       (w_rb),
    .o_imm      (w_imm),
    .o_wr_en    (w_wr_en),
    .o_jmpz     (w_jmpz),
    .o_halt     (w_halt),
    .o_bsel     (w_bsel),
    .o_alu_func (w_alu_func)
  );

  // start is honoured only from the two non-busy states
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_HALT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pc   <= '0;
      r_ir   <= '0;
      r_zero <= 1'b0;
    end else begin
      if (w_start_ok) begin
        r_pc <= '0;
      end
      if ((r_state == ST_FETCH) && imem_ack) begin
        r_ir <= imem_data;
      end
      if (r_state == ST_EXECUTE) begin
        r_zero <= alu_zero;
      end
      // HALT leaves pc pointing at the HALT instruction
      if (r_state == ST_WRITEBACK) begin
        if (w_jmpz && r_zero) begin
          r_pc <= PC_W'(w_imm);
        end else if (!w_halt) begin
          r_pc <= r_pc + PC_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    rf_ra        = 1'b0;
    rf_rb        = 1'b0;
    rf_wa        = 1'b0;
    rf_we        = 1'b0;
    alu_func     = 3'b000;
    alu_bsel     = 1'b0;
    busy         = 1'b1;
    halted       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        busy = 1'b0;
        if (w_start_ok) w_next_state = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = ST_DECODE;
      end
      ST_DECODE: begin
        rf_ra        = w_rd;
        rf_rb        = w_rb;
        w_next_state = ST_EXECUTE;
      end
      ST_EXECUTE: begin
        alu_func     = w_alu_func;
        alu_bsel     = w_bsel;
        w_next_state = ST_WRITEBACK;
      end
      ST_WRITEBACK: begin
        rf_we = w_wr_en;
        rf_wa = w_wr_en & w_rd;
        if (w_halt)       w_next_state = ST_HALT;
        else if (step_en) w_next_state = ST_STEP_WAIT;
        else              w_next_state = ST_FETCH;
      end
      ST_STEP_WAIT: begin
        if (step || !step_en) w_next_state = ST_FETCH;
      end
      ST_HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
        if (w_start_ok) w_next_state = ST_FETCH;
      end
      default: begin
        busy         = 1'b0;
        w_next_state = ST_IDLE;
      end
    endcase
  end

  assign imem_addr = r_pc;
  assign pc        = r_pc;
  assign imm       = DATA_W'(w_imm);

endmodule

// File: tb/tb_proc_sequencer.sv
// tb/tb_proc_sequencer.sv - self-checking bench for proc_sequencer
module tb_proc_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_WAIT = 2;
  localparam int M_HALT = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       step_en = 1'b0;
  logic       step = 1'b0;
  logic       imem_req;
  logic [3:0] imem_addr;
  logic       imem_ack = 1'b0;
  logic [7:0] imem_data = 8'h00;
  logic       rf_ra, rf_rb, rf_wa, rf_we;
  logic [2:0] alu_func;
  logic       alu_bsel;
  logic [3:0] imm;
  logic       alu_zero = 1'b0;
  logic       busy, halted;
  logic [3:0] pc;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [16];
  logic       zmap [16];
  int         ack_delay = 0;
  int         wcnt = 0;
  logic       spur_en = 1'b0;
  int         we_q [$];

  int         m_mode = M_IDLE;
  int         m_phase = 0;
  logic [3:0] m_pc = 4'd0;
  logic [7:0] m_ir = 8'h00;
  logic       m_zero = 1'b0;

  proc_sequencer #(.PC_W(4), .DATA_W(4)) dut (
    .clk(clk), .reset(reset), .start(start), .step_en(step_en), .step(step),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
    .rf_ra(rf_ra), .rf_rb(rf_rb), .rf_wa(rf_wa), .rf_we(rf_we),
    .alu_func(alu_func), .alu_bsel(alu_bsel), .imm(imm), .alu_zero(alu_zero),
    .busy(busy), .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  function automatic logic [22:0] dut_out();
    return {imem_req, imem_addr, rf_ra, rf_rb, rf_wa, rf_we, alu_func, alu_bsel,
            imm, busy, halted, pc};
  endfunction

  // Instruction-level model: mode + phase counter 0..3 within an instruction
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_mode = M_IDLE; m_phase = 0; m_pc = 4'd0; m_ir = 8'h00; m_zero = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE, M_HALT: if (start) begin m_mode = M_RUN; m_phase = 0; m_pc = 4'd0; end
        M_WAIT: if (step || !step_en) begin m_mode = M_RUN; m_phase = 0; end
        default: begin
          if (m_phase == 0) begin
            if (imem_ack) begin m_ir = imem_data; m_phase = 1; end
          end else if (m_phase == 1) begin
            m_phase = 2;
          end else if (m_phase == 2) begin
            m_zero = alu_zero; m_phase = 3;
          end else begin
            if (m_ir[7:5] == 3'd7) begin
              m_mode = M_HALT;
            end else begin
              if (m_ir[7:5] == 3'd6 && m_zero) m_pc = m_ir[3:0];
              else m_pc = m_pc + 4'd1;
              m_phase = 0;
              if (step_en) m_mode = M_WAIT;
            end
          end
        end
      endcase
    end
  end

  function automatic logic [22:0] model_out();
    logic run; logic [2:0] op; logic rd;
    logic e_req, e_ra, e_rb, e_we, e_wa, e_bsel; logic [2:0] e_func;
    run    = (m_mode == M_RUN);
    op     = m_ir[7:5];
    rd     = m_ir[4];
    e_req  = run && (m_phase == 0);
    e_ra   = (run && m_phase == 1) ? rd : 1'b0;
    e_rb   = (run && m_phase == 1) ? ((op == 3'd6) ? rd : m_ir[0]) : 1'b0;
    e_func = (run && m_phase == 2) ? ((op == 3'd6) ? 3'd4 : op) : 3'd0;
    e_bsel = run && (m_phase == 2) && (op == 3'd1 || op == 3'd5);
    e_we   = run && (m_phase == 3) && (op >= 3'd1) && (op <= 3'd5);
    e_wa   = e_we ? rd : 1'b0;
    return {e_req, m_pc, e_ra, e_rb, e_wa, e_we, e_func, e_bsel, m_ir[3:0],
            (m_mode == M_RUN || m_mode == M_WAIT), (m_mode == M_HALT), m_pc};
  endfunction

  // Memory responder, ALU zero source and per-cycle compare, all on the falling edge
  always @(negedge clk) begin
    if (imem_req === 1'b1) begin
      if (wcnt >= ack_delay) begin
        imem_ack = 1'b1; imem_data = mem[imem_addr]; wcnt = 0;
      end else begin
        imem_ack = 1'b0; imem_data = 8'hFF; wcnt++;
      end
    end else begin
      wcnt = 0; imem_ack = spur_en; imem_data = 8'hFF;
    end
    alu_zero = zmap[imem_addr];
  end

  always @(negedge clk) begin
    logic [22:0] act_v, exp_v;
    act_v = dut_out();
    exp_v = model_out();
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL cycle_outputs t=%0t actual=%h expected=%h", $time, act_v, exp_v);
    end
    if (rf_we === 1'b1) we_q.push_back(int'(rf_wa));
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  function automatic int we_at(input int i);
    return (we_q.size() > i) ? we_q[i] : 9;
  endfunction

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) begin mem[i] = 8'h00; zmap[i] = 1'b0; end
  endtask

  task automatic load_prog_a();
    clear_mem();
    mem[0] = 8'h25; mem[1] = 8'h33; mem[2] = 8'h41; mem[3] = 8'hE0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_halt(input int max, output int busy_cyc);
    int n;
    busy_cyc = 0; n = 0;
    while (halted !== 1'b1 && n < max) begin
      if (busy === 1'b1) busy_cyc++;
      @(negedge clk);
      n++;
    end
    if (n >= max) chk("halt_timeout", 0, 1);
  endtask

  initial begin
    int bc, rc, n;
    logic addr_ok;
    logic [3:0] imm_wait, prev;
    logic [3:0] pcs [$];
    clear_mem();
    #3 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", 32'(dut_out()), 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_without_start", 32'(busy), 0);

    // Straight-line program, zero-wait fetch
    load_prog_a();
    we_q.delete();
    pulse_start();
    wait_halt(100, bc);
    chk("busy_cycles_prog_a", bc, 16);
    chk("we_pulse_count", we_q.size(), 3);
    chk("we0_wa", we_at(0), 0);
    chk("we1_wa", we_at(1), 1);
    chk("we2_wa", we_at(2), 0);
    chk("halted_prog_a", 32'(halted), 1);
    chk("pc_prog_a", 32'(pc), 3);

    // Delayed ack with spurious acks while req is low
    clear_mem();
    mem[0] = 8'h36; mem[1] = 8'hE0;
    ack_delay = 3; spur_en = 1'b1;
    @(negedge clk);
    pulse_start();
    rc = 0; addr_ok = 1'b1; imm_wait = 4'hx;
    while (imem_req === 1'b1 && rc < 20) begin
      rc++;
      if (imem_addr !== 4'd0) addr_ok = 1'b0;
      if (rc == 2) imm_wait = imm;
      @(negedge clk);
    end
    chk("req_held_cycles", rc, 4);
    chk("addr_stable", 32'(addr_ok), 1);
    chk("ir_held_during_wait", 32'(imm_wait), 0);
    chk("decode_imm", 32'(imm), 6);
    chk("decode_ra", 32'(rf_ra), 1);
    wait_halt(100, bc);
    chk("pc_delay_prog", 32'(pc), 1);
    spur_en = 1'b0; ack_delay = 0;

    // Conditional jumps and pc wrap
    clear_mem();
    mem[0] = 8'hC9; mem[9] = 8'hD5; mem[10] = 8'hCF; mem[15] = 8'h00;
    zmap[0] = 1'b1; zmap[10] = 1'b1;
    @(negedge clk);
    pulse_start();
    prev = pc; n = 0;
    while (pcs.size() < 4 && n < 200) begin
      @(negedge clk);
      n++;
      if (pc !== prev) begin pcs.push_back(pc); prev = pc; end
    end
    if (n >= 200) chk("jmp_timeout", 0, 1);
    chk("jmpz_taken", (pcs.size() > 0) ? 32'(pcs[0]) : 99, 9);
    chk("jmpz_not_taken", (pcs.size() > 1) ? 32'(pcs[1]) : 99, 10);
    chk("jmpz_to_15", (pcs.size() > 2) ? 32'(pcs[2]) : 99, 15);
    chk("pc_wrap", (pcs.size() > 3) ? 32'(pcs[3]) : 99, 0);
    #2 reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;

    // Single-step
    clear_mem();
    mem[0] = 8'h21; mem[1] = 8'h32; mem[2] = 8'hE0;
    step_en = 1'b1;
    we_q.delete();
    @(negedge clk);
    pulse_start();
    repeat (8) @(negedge clk);
    chk("step_park_pc", 32'(pc), 1);
    chk("step_park_busy", 32'(busy), 1);
    chk("step_park_req", 32'(imem_req), 0);
    chk("step_park_we", we_q.size(), 1);
    step = 1'b1;
    @(negedge clk);
    step = 1'b0;
    repeat (8) @(negedge clk);
    chk("step_one_pc", 32'(pc), 2);
    chk("step_one_we", we_q.size(), 2);
    chk("step_one_not_halted", 32'(halted), 0);
    step_en = 1'b0;
    wait_halt(50, bc);
    chk("step_release_pc", 32'(pc), 2);

    // Reset during fetch
    load_prog_a();
    ack_delay = 3;
    @(negedge clk);
    pulse_start();
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("rst_fetch_outputs", 32'(dut_out()), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_fetch_stays_idle", 32'(busy), 0);

    // Reset during writeback
    ack_delay = 0;
    pulse_start();
    n = 0;
    while (rf_we !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) chk("we_timeout", 0, 1);
    #2 reset = 1'b0;
    #1 chk("rst_wb_we", 32'(rf_we), 0);
    chk("rst_wb_outputs", 32'(dut_out()), 0);
    we_q.delete();
    repeat (2) @(negedge clk);
    chk("rst_wb_no_pulse", we_q.size(), 0);
    reset = 1'b1;
    @(negedge clk);
    pulse_start();
    chk("restart_req", 32'(imem_req), 1);
    chk("restart_addr", 32'(imem_addr), 0);
    wait_halt(100, bc);
    chk("restart_pc", 32'(pc), 3);

    // Start in HALT restarts; start while busy is ignored
    pulse_start();
    chk("halt_restart_halted", 32'(halted), 0);
    chk("halt_restart_pc", 32'(pc), 0);
    chk("halt_restart_busy", 32'(busy), 1);
    we_q.delete();
    repeat (5) @(negedge clk);
    pulse_start();
    wait_halt(100, bc);
    chk("busy_start_pc", 32'(pc), 3);
    chk("busy_start_we", we_q.size(), 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proc_sequencer.md
PROC_SEQUENCER -- requirements
Module: proc_sequencer

Interface
REQ-001 SHALL have parameter PC_W, default 4, meaning program counter and instruction address width.
REQ-002 SHALL have parameter DATA_W, default 4, meaning datapath word and immediate width.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1  begin execution from pc 0 when IDLE or HALT.
REQ-006 SHALL have port step_en  input  1  single-step mode enable.
REQ-007 SHALL have port step  input  1  advance one instruction while in STEP_WAIT.
REQ-008 SHALL have port imem_req  output  1  instruction fetch request.
REQ-009 SHALL have port imem_addr  output  PC_W  fetch address, equal to pc.
REQ-010 SHALL have port imem_ack  input  1  fetch data valid this cycle.
REQ-011 SHALL have port imem_data  input  8  instruction: op[7:5], rd[4], imm[3:0]; rs = imm[0].
REQ-012 SHALL have ports rf_ra, rf_rb, rf_wa  output  1 each  register-file read A, read B and write addresses.
REQ-013 SHALL have port rf_we  output  1  register-file write enable.
REQ-014 SHALL have port alu_func  output  3  ALU operation; equals op, except JMPZ drives 100.
REQ-015 SHALL have ports alu_bsel  output  1 (0 = register B, 1 = immediate) and imm  output  DATA_W  zero-extended imm field.
REQ-016 SHALL have port alu_zero  input  1  ALU result is zero; sampled only in EXECUTE.
REQ-017 SHALL have ports busy  output  1, halted  output  1 and pc  output  PC_W  status.

Function
REQ-018 SHALL use the FSM states IDLE, FETCH, DECODE, EXECUTE, WRITEBACK, STEP_WAIT and HALT.
REQ-019 SHALL move IDLE->FETCH on start, clear pc to 0 and assert busy.
REQ-020 SHALL hold imem_req high in FETCH until imem_ack; on ack latch imem_data into IR, then go to DECODE.
REQ-021 SHALL ignore imem_ack when imem_req is low.
REQ-022 SHALL, in DECODE, drive rf_ra = rd and rf_rb = rs (rd for JMPZ) for one cycle.
REQ-023 SHALL, in EXECUTE, drive alu_func and alu_bsel (1 for LOADI and INC, else 0), and register alu_zero.
REQ-024 SHALL, in WRITEBACK, pulse rf_we with rf_wa = rd for LOADI(001), ADD(010), SUB(011), MOV(100) and INC(101); rf_we SHALL stay 0 for NOP(000), JMPZ(110) and HALT(111).
REQ-025 SHALL, in WRITEBACK, update pc to imm for JMPZ with registered zero = 1, else pc+1 modulo 2^PC_W (wraps to 0).
REQ-026 SHALL go from WRITEBACK to HALT on HALT, to STEP_WAIT if step_en = 1, else to FETCH.
REQ-027 SHALL leave STEP_WAIT to FETCH on step = 1, or when step_en drops to 0.
REQ-028 SHALL, in HALT, set halted = 1, busy = 0 and pc unchanged; start SHALL restart from pc 0 with halted cleared.
REQ-029 SHALL ignore start while busy.
REQ-030 SHALL take 4 cycles per instruction when imem_ack coincides with imem_req, plus one cycle per fetch wait cycle.

Reset
REQ-031 SHALL, while reset = 0, immediately force state IDLE, pc 0, IR 0, all outputs 0, even mid-fetch or mid-writeback.
REQ-032 SHALL leave IDLE only on the first start after reset deasserts.

Structure
REQ-033 SHALL take the opcode constants, state encoding and instruction field positions from shared package proc_pkg.
REQ-034 SHALL implement instruction decode in one combinational sub-module, seq_decode (IR in, write/jump/bsel/alu_func out).

Verification
REQ-035 Bench SHALL check: program LOADI r0,5; LOADI r1,3; ADD r0,r1; HALT with 0-wait ack -> rf_we pulses with wa 0,1,0; HALT reached after 16 cycles; halted = 1; pc = 3.
REQ-036 Bench SHALL check: imem_ack delayed 3 cycles -> imem_req held 4 cycles with imem_addr stable; IR is loaded only on ack.
REQ-037 Bench SHALL check: JMPZ r0,#9 with alu_zero = 1 -> pc = 9; with alu_zero = 0 -> pc + 1; pc 15 + NOP -> pc 0.
REQ-038 Bench SHALL check: step_en = 1 -> parks in STEP_WAIT after each WRITEBACK; a single step pulse advances exactly one instruction.
REQ-039 Bench SHALL check: reset asserted during FETCH and during WRITEBACK -> outputs 0 immediately, no rf_we pulse; start after release runs from pc 0.
REQ-040 Bench SHALL check: start while busy -> no effect; start in HALT -> restart at pc 0 with halted = 0.
